request_bank: RTL and testbench

Parametrised floor-request register bank for the elevator controller. It generalises the fixed 5-floor, 2-bit-per-floor load/shift register to any floor count. On top of load and bidirectional shift, it adds:
- sticky per-button request capture,
- per-floor service clear,
- a pending summary,
- a registered nearest-target search that feeds the motion FSM.

---
 rtl/request_bank.sv | 137 +++++++++++++
 tb/tb_request_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/request_bank.sv
// Floor-request register bank: load / bidirectional shift, sticky button capture,
// per-floor service clear, pending summary and a registered nearest-target search.
module request_bank #(
  parameter  int FLOORS         = 5,
  parameter  int BITS_PER_FLOOR = 2,
  localparam int W              = FLOORS * BITS_PER_FLOOR,
  localparam int FW             = $clog2(FLOORS),
  localparam int CW             = $clog2(FLOORS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [W-1:0]      parallel_in,
  input  logic              shift_en,
  input  logic              shift_dir,
  input  logic              shift_in,
  input  logic [W-1:0]      set_req,
  input  logic              clr_en,
  input  logic [FW-1:0]     clr_floor,
  input  logic [FW-1:0]     cur_floor,
  input  logic              dir_up,
  output logic              shift_out,
  output logic [W-1:0]      reg_content,
  output logic [FLOORS-1:0] floor_pending,
  output logic              any_pending,
  output logic [CW-1:0]     pending_count,
  output logic              new_req,
  output logic              target_valid,
  output logic [FW-1:0]     target_floor
);

  logic [W-1:0]      bank_reg, bank_next;
  logic [W-1:0]      clr_mask, set_merge;
  logic              rise_reg, rise_next;
  logic              new_req_reg;
  logic              target_valid_reg, target_valid_next;
  logic [FW-1:0]     target_floor_reg, target_floor_next;
  logic [FLOORS-1:0] above, below;
  logic              cur_ok;
  logic              up_hit, dn_hit, pref_hit, alt_hit;
  logic [FW-1:0]     up_idx, dn_idx, pref_idx, alt_idx;

  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_floor
      assign floor_pending[gi] = |bank_reg[gi*BITS_PER_FLOOR +: BITS_PER_FLOOR];
      // Out-of-range clr_floor matches no floor, so it clears nothing.
      assign clr_mask[gi*BITS_PER_FLOOR +: BITS_PER_FLOOR] =
        {BITS_PER_FLOOR{clr_en && (clr_floor == FW'(gi))}};
      assign above[gi] = floor_pending[gi] && (FW'(gi) > cur_floor);
      assign below[gi] = floor_pending[gi] && (FW'(gi) < cur_floor);
    end
  endgenerate

  assign reg_content  = bank_reg;
  assign any_pending  = |floor_pending;
  assign shift_out    = shift_dir ? bank_reg[0] : bank_reg[W-1];
  assign new_req      = new_req_reg;
  assign target_valid = target_valid_reg;
  assign target_floor = target_floor_reg;
  assign cur_ok       = ({1'b0, cur_floor} < (FW+1)'(FLOORS));

  always_comb begin
    pending_count = '0;
    for (int f = 0; f < FLOORS; f++)
      pending_count = pending_count + CW'(floor_pending[f]);
  end

  // Clear is applied after the OR so a press at the served floor is absorbed.
  always_comb begin
    set_merge = (bank_reg | set_req) & ~clr_mask;
    bank_next = set_merge;
    rise_next = |(set_merge & ~bank_reg);
    if (load) begin
      bank_next = parallel_in;
      rise_next = 1'b0;
    end else if (shift_en) begin
      bank_next = shift_dir ? {shift_in, bank_reg[W-1:1]} : {bank_reg[W-2:0], shift_in};
      rise_next = 1'b0;
    end
  end

  always_comb begin
    up_hit = 1'b0;
    up_idx = '0;
    dn_hit = 1'b0;
    dn_idx = '0;
    // Descending scan leaves the lowest floor above; ascending leaves the highest below.
    for (int f = FLOORS - 1; f >= 0; f--)
      if (above[f]) begin
        up_hit = 1'b1;
        up_idx = FW'(f);
      end
    for (int f = 0; f < FLOORS; f++)
      if (below[f]) begin
        dn_hit = 1'b1;
        dn_idx = FW'(f);
      end
    pref_hit = dir_up ? up_hit : dn_hit;
    pref_idx = dir_up ? up_idx : dn_idx;
    alt_hit  = dir_up ? dn_hit : up_hit;
    alt_idx  = dir_up ? dn_idx : up_idx;

    target_valid_next = 1'b0;
    target_floor_next = target_floor_reg;
    if (cur_ok) begin
      if (floor_pending[cur_floor]) begin
        target_valid_next = 1'b1;
        target_floor_next = cur_floor;
      end else if (pref_hit) begin
        target_valid_next = 1'b1;
        target_floor_next = pref_idx;
      end else if (alt_hit) begin
        target_valid_next = 1'b1;
        target_floor_next = alt_idx;
      end
    end
  end

  // new_req is delayed one stage so it aligns with the target outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_reg         <= '0;
      rise_reg         <= 1'b0;
      new_req_reg      <= 1'b0;
      target_valid_reg <= 1'b0;
      target_floor_reg <= '0;
    end else begin
      bank_reg         <= bank_next;
      rise_reg         <= rise_next;
      new_req_reg      <= rise_reg;
      target_valid_reg <= target_valid_next;
      target_floor_reg <= target_floor_next;
    end
  end

endmodule

// File: tb/tb_request_bank.sv
// Scoreboard bench for request_bank: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one cycle later on the falling edge.
module tb_request_bank;

  typedef struct {
    string       name;
    logic [23:0] rg;
    logic        nr;
    logic [2:0]  m;   // [0] summary, [1] target, [2] shift_out
    logic [7:0]  fp;
    logic [3:0]  pc;
    logic        tv;
    logic [2:0]  tf;
    logic        so;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance: 5 floors x 2 bits
  logic       load_a = 0, shift_en_a = 0, shift_dir_a = 0, shift_in_a = 0, clr_en_a = 0, dir_up_a = 0;
  logic [9:0] parallel_in_a = '0, set_req_a = '0;
  logic [2:0] clr_floor_a = '0, cur_floor_a = '0;
  logic       shift_out_a, any_pending_a, new_req_a, target_valid_a;
  logic [9:0] reg_a;
  logic [4:0] fp_a;
  logic [2:0] pc_a, tf_a;

  request_bank dut_a (
    .clk(clk), .rst(rst), .load(load_a), .parallel_in(parallel_in_a),
    .shift_en(shift_en_a), .shift_dir(shift_dir_a), .shift_in(shift_in_a),
    .set_req(set_req_a), .clr_en(clr_en_a), .clr_floor(clr_floor_a),
    .cur_floor(cur_floor_a), .dir_up(dir_up_a), .shift_out(shift_out_a),
    .reg_content(reg_a), .floor_pending(fp_a), .any_pending(any_pending_a),
    .pending_count(pc_a), .new_req(new_req_a), .target_valid(target_valid_a),
    .target_floor(tf_a)
  );

  // wide instance: 8 floors x 3 bits
  logic        load_b = 0, shift_en_b = 0, shift_dir_b = 0, shift_in_b = 0, clr_en_b = 0, dir_up_b = 1;
  logic [23:0] parallel_in_b = '0, set_req_b = '0;
  logic [2:0]  clr_floor_b = '0, cur_floor_b = '0;
  logic        shift_out_b, any_pending_b, new_req_b, target_valid_b;
  logic [23:0] reg_b;
  logic [7:0]  fp_b;
  logic [3:0]  pc_b;
  logic [2:0]  tf_b;

  request_bank #(.FLOORS(8), .BITS_PER_FLOOR(3)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .parallel_in(parallel_in_b),
    .shift_en(shift_en_b), .shift_dir(shift_dir_b), .shift_in(shift_in_b),
    .set_req(set_req_b), .clr_en(clr_en_b), .clr_floor(clr_floor_b),
    .cur_floor(cur_floor_b), .dir_up(dir_up_b), .shift_out(shift_out_b),
    .reg_content(reg_b), .floor_pending(fp_b), .any_pending(any_pending_b),
    .pending_count(pc_b), .new_req(new_req_b), .target_valid(target_valid_b),
    .target_floor(tf_b)
  );

  function automatic exp_t mk(string n, logic [23:0] rg, logic nr, logic [2:0] m,
                              logic [7:0] fp, logic [3:0] pc, logic tv, logic [2:0] tf, logic so);
    exp_t e;
    e.name = n; e.rg = rg; e.nr = nr; e.m = m;
    e.fp = fp; e.pc = pc; e.tv = tv; e.tf = tf; e.so = so;
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, want);
    end
  endtask

  task automatic cyc_a(input logic ld, input logic [9:0] pin, input logic se, input logic sd,
                       input logic si, input logic [9:0] sr, input logic ce, input logic [2:0] cf,
                       input logic [2:0] cur, input logic du, input exp_t e);
    @(negedge clk);
    #1;
    load_a = ld; parallel_in_a = pin; shift_en_a = se; shift_dir_a = sd; shift_in_a = si;
    set_req_a = sr; clr_en_a = ce; clr_floor_a = cf; cur_floor_a = cur; dir_up_a = du;
    qa.push_back(e);
    @(posedge clk);
  endtask

  task automatic cyc_b(input logic [23:0] sr, input logic [2:0] cur, input exp_t e);
    @(negedge clk);
    #1;
    set_req_b = sr; cur_floor_b = cur;
    qb.push_back(e);
    @(posedge clk);
  endtask

  // monitor: one expectation per queue per falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk({"A.", e.name, ".reg"}, 32'(reg_a), 32'(e.rg));
        chk({"A.", e.name, ".new_req"}, 32'(new_req_a), 32'(e.nr));
        if (e.m[0]) begin
          chk({"A.", e.name, ".floor_pending"}, 32'(fp_a), 32'(e.fp));
          chk({"A.", e.name, ".any_pending"}, 32'(any_pending_a), 32'(|e.fp));
          chk({"A.", e.name, ".pending_count"}, 32'(pc_a), 32'(e.pc));
        end
        if (e.m[1]) begin
          chk({"A.", e.name, ".target_valid"}, 32'(target_valid_a), 32'(e.tv));
          chk({"A.", e.name, ".target_floor"}, 32'(tf_a), 32'(e.tf));
        end
        if (e.m[2]) chk({"A.", e.name, ".shift_out"}, 32'(shift_out_a), 32'(e.so));
        $display("txn A %s reg=%h new_req=%b tv=%b tf=%0d", e.name, reg_a, new_req_a, target_valid_a, tf_a);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk({"B.", e.name, ".reg"}, 32'(reg_b), 32'(e.rg));
        chk({"B.", e.name, ".new_req"}, 32'(new_req_b), 32'(e.nr));
        if (e.m[0]) begin
          chk({"B.", e.name, ".floor_pending"}, 32'(fp_b), 32'(e.fp));
          chk({"B.", e.name, ".any_pending"}, 32'(any_pending_b), 32'(|e.fp));
          chk({"B.", e.name, ".pending_count"}, 32'(pc_b), 32'(e.pc));
        end
        if (e.m[1]) begin
          chk({"B.", e.name, ".target_valid"}, 32'(target_valid_b), 32'(e.tv));
          chk({"B.", e.name, ".target_floor"}, 32'(tf_b), 32'(e.tf));
        end
        if (e.m[2]) chk({"B.", e.name, ".shift_out"}, 32'(shift_out_b), 32'(e.so));
        $display("txn B %s reg=%h new_req=%b tv=%b tf=%0d", e.name, reg_b, new_req_b, target_valid_b, tf_b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held while every input toggles
    for (int i = 0; i < 4; i++)
      cyc_a(1'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            10'($urandom), 1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
            mk("rst_hold", 24'h0, 1'b0, 3'b111, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0));
    #2 rst = 1'b0;

    // sticky set and delayed new_req pulse
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h004, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("set004", 24'h004, 1'b0, 3'b111, 8'h02, 4'd1, 1'b0, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("newreq", 24'h004, 1'b1, 3'b011, 8'h02, 4'd1, 1'b1, 3'd1, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("newreq_end", 24'h004, 1'b0, 3'b010, 8'h00, 4'd0, 1'b1, 3'd1, 1'b0));

    // load beats shift and set/clear; then shifts both ways
    cyc_a(1'b1, 10'h2A5, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b1, 3'd0, 3'd0, 1'b1,
          mk("load", 24'h2A5, 1'b0, 3'b101, 8'h1F, 4'd5, 1'b0, 3'd0, 1'b1));
    cyc_a(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("shl", 24'h14B, 1'b0, 3'b101, 8'h1B, 4'd4, 1'b0, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("shr", 24'h0A5, 1'b0, 3'b101, 8'h0F, 4'd4, 1'b0, 3'd0, 1'b1));

    // clear wins over set; out-of-range clear ignored
    cyc_a(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("ld0", 24'h000, 1'b0, 3'b001, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h030, 1'b1, 3'd2, 3'd0, 1'b1,
          mk("collide", 24'h000, 1'b0, 3'b001, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0));
    cyc_a(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("ld3ff", 24'h3FF, 1'b0, 3'b001, 8'h1F, 4'd5, 1'b0, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 3'd7, 3'd2, 1'b1,
          mk("clr7", 24'h3FF, 1'b0, 3'b001, 8'h1F, 4'd5, 1'b0, 3'd0, 1'b0));

    // target search
    cyc_a(1'b1, 10'h101, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd2, 1'b1,
          mk("tgt_here", 24'h101, 1'b0, 3'b011, 8'h11, 4'd2, 1'b1, 3'd2, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd2, 1'b1,
          mk("tgt_up", 24'h101, 1'b0, 3'b010, 8'h00, 4'd0, 1'b1, 3'd4, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd2, 1'b0,
          mk("tgt_dn", 24'h101, 1'b0, 3'b010, 8'h00, 4'd0, 1'b1, 3'd0, 1'b0));
    cyc_a(1'b1, 10'h004, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd2, 1'b1,
          mk("tgt_ld004", 24'h004, 1'b0, 3'b010, 8'h00, 4'd0, 1'b1, 3'd4, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd2, 1'b1,
          mk("tgt_fallback", 24'h004, 1'b0, 3'b010, 8'h00, 4'd0, 1'b1, 3'd1, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 3'd1, 3'd2, 1'b1,
          mk("clr1", 24'h000, 1'b0, 3'b011, 8'h00, 4'd0, 1'b1, 3'd1, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd2, 1'b1,
          mk("tgt_none", 24'h000, 1'b0, 3'b011, 8'h00, 4'd0, 1'b0, 3'd1, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h001, 1'b0, 3'd0, 3'd2, 1'b1,
          mk("set0", 24'h001, 1'b0, 3'b011, 8'h01, 4'd1, 1'b0, 3'd1, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd7, 1'b1,
          mk("cur7", 24'h001, 1'b1, 3'b010, 8'h00, 4'd0, 1'b0, 3'd1, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("cur0", 24'h001, 1'b0, 3'b010, 8'h00, 4'd0, 1'b1, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h0C1, 1'b1, 3'd0, 3'd0, 1'b1,
          mk("setclr", 24'h0C0, 1'b0, 3'b011, 8'h08, 4'd1, 1'b1, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("setclr_nr", 24'h0C0, 1'b1, 3'b010, 8'h00, 4'd0, 1'b1, 3'd3, 1'b0));

    // asynchronous reset pulse in the middle of a shift run
    cyc_a(1'b1, 10'h2A5, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("mid_ld", 24'h2A5, 1'b0, 3'b000, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("mid_sh1", 24'h14A, 1'b0, 3'b100, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0));
    cyc_a(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("mid_rst", 24'h000, 1'b0, 3'b111, 8'h00, 4'd0, 1'b0, 3'd0, 1'b0));
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    cyc_a(1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 10'h000, 1'b0, 3'd0, 3'd0, 1'b1,
          mk("mid_after", 24'h001, 1'b0, 3'b111, 8'h01, 4'd1, 1'b0, 3'd0, 1'b0));

    // wide instance
    cyc_b(24'h800000, 3'd7,
          mk("set23", 24'h800000, 1'b0, 3'b111, 8'h80, 4'd1, 1'b0, 3'd0, 1'b1));
    cyc_b(24'h000000, 3'd7,
          mk("cur7", 24'h800000, 1'b1, 3'b011, 8'h80, 4'd1, 1'b1, 3'd7, 1'b0));

    repeat (2) @(negedge clk);
    #1;
    chk("drain", 32'(qa.size() + qb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
